// File: rtl/mc_scan_sequencer.sv
//==============================================================================
// Module   : mc_scan_sequencer
// Purpose  : Raster-scan sequencer for the master controller. Per pixel it
//            commands a galvo move, waits for SPI completion, settles for a
//            programmable time, issues GO to input_top and waits for
//            pixel_done (with timeout). Single-frame, continuous and point
//            (stare) modes, with frame counting.
// Options  : MC_SERPENTINE_EN - odd rows scan right-to-left (no flyback).
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module mc_scan_sequencer #(
  parameter int              H_W     = 11,
  parameter int              V_W     = 11,
  parameter int              CYC_W   = 10,
  parameter int              TO_W    = 16,
  parameter logic [TO_W-1:0] TIMEOUT = 16'hFFFF,
  parameter int              FRAME_W = 16
) (
  input  logic               clk_stream,
  input  logic               rst_stream,
  input  logic               run,
  input  logic               halt,
  input  logic [1:0]         mode,
  input  logic [CYC_W-1:0]   cycle_time,
  input  logic [H_W-1:0]     h_last,
  input  logic [V_W-1:0]     v_last,
  input  logic               timeout_clr,
  input  logic               galvo_spi_done,
  input  logic               pixel_done,
  output logic               galvo_req,
  output logic [H_W-1:0]     galvoh,
  output logic [V_W-1:0]     galvov,
  output logic               go,
  output logic               busy,
  output logic               frame_done,
  output logic [FRAME_W-1:0] frame_count,
  output logic               pixel_timeout
);

  // Last timeout-counter value before a forced advance.
  localparam logic [TO_W-1:0] TO_LAST = TIMEOUT - 1'b1;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_GALVO   = 3'd1,
    S_SETTLE  = 3'd2,
    S_PIXEL   = 3'd3,
    S_ADVANCE = 3'd4
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic               entry;
  logic               run_q;
  logic               halt_q;
  logic               run_edge;
  logic               halt_edge;
  logic [1:0]         mode_q;
  logic [CYC_W-1:0]   cycle_q;
  logic [H_W-1:0]     h_last_q;
  logic [V_W-1:0]     v_last_q;
  logic [CYC_W-1:0]   settle_cnt;
  logic [TO_W-1:0]    to_cnt;
  logic               timeout_hit;
  logic               point_mode;
  logic               cont_mode;
  logic               row_end;
  logic               col_end;
  logic [H_W-1:0]     h_step;
  logic [H_W-1:0]     h_row_start;
  logic               start_scan;
  logic               settle_load;
  logic               step_h;
  logic               step_row;
  logic               wrap_frame;

  assign run_edge    = run & ~run_q;
  assign halt_edge   = halt & ~halt_q;
  assign busy        = (state != S_IDLE);
  // Reserved mode 3 decodes as neither continuous nor point, i.e. single frame.
  assign point_mode  = (mode_q == 2'd2);
  assign cont_mode   = (mode_q == 2'd1);
  assign timeout_hit = (state == S_PIXEL) && (to_cnt == TO_LAST);
  assign col_end     = (galvov == v_last_q);

  // Scan-direction dependent row stepping.
  always_comb begin
`ifdef MC_SERPENTINE_EN
    if (galvov[0]) begin
      row_end = (galvoh == '0);
      h_step  = galvoh - 1'b1;
    end else begin
      row_end = (galvoh == h_last_q);
      h_step  = galvoh + 1'b1;
    end
    // Row change keeps the beam at the end it finished on.
    h_row_start = galvoh;
`else
    row_end     = (galvoh == h_last_q);
    h_step      = galvoh + 1'b1;
    h_row_start = '0;
`endif
  end

  // Input edge detectors for run and halt.
  always_ff @(posedge clk_stream or posedge rst_stream) begin
    if (rst_stream) begin
      run_q  <= 1'b0;
      halt_q <= 1'b0;
    end else begin
      run_q  <= run;
      halt_q <= halt;
    end
  end

  // State register; entry marks the first cycle spent in a newly entered state.
  always_ff @(posedge clk_stream or posedge rst_stream) begin
    if (rst_stream) begin
      state <= S_IDLE;
      entry <= 1'b0;
    end else begin
      state <= state_nxt;
      entry <= (state_nxt != state);
    end
  end

  // Next-state and strobe decode; halt edge overrides everything.
  always_comb begin
    state_nxt   = state;
    galvo_req   = 1'b0;
    go          = 1'b0;
    frame_done  = 1'b0;
    start_scan  = 1'b0;
    settle_load = 1'b0;
    step_h      = 1'b0;
    step_row    = 1'b0;
    wrap_frame  = 1'b0;
    if (halt_edge) begin
      state_nxt = S_IDLE;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (run_edge) begin
            start_scan = 1'b1;
            state_nxt  = S_GALVO;
          end
        end
        S_GALVO: begin
          galvo_req = entry;
          if (galvo_spi_done) begin
            settle_load = 1'b1;
            state_nxt   = S_SETTLE;
          end
        end
        S_SETTLE: begin
          if (settle_cnt == '0) state_nxt = S_PIXEL;
        end
        S_PIXEL: begin
          go = entry;
          if (pixel_done || timeout_hit) state_nxt = S_ADVANCE;
        end
        S_ADVANCE: begin
          if (point_mode) begin
            settle_load = 1'b1;
            state_nxt   = S_SETTLE;
          end else if (!row_end) begin
            step_h    = 1'b1;
            state_nxt = S_GALVO;
          end else if (!col_end) begin
            step_row  = 1'b1;
            state_nxt = S_GALVO;
          end else begin
            frame_done = 1'b1;
            wrap_frame = 1'b1;
            state_nxt  = cont_mode ? S_GALVO : S_IDLE;
          end
        end
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  // Configuration snapshot taken at scan start; inputs are ignored mid-scan.
  always_ff @(posedge clk_stream or posedge rst_stream) begin
    if (rst_stream) begin
      mode_q   <= 2'd0;
      cycle_q  <= '0;
      h_last_q <= '0;
      v_last_q <= '0;
    end else if (start_scan) begin
      mode_q   <= mode;
      cycle_q  <= cycle_time;
      h_last_q <= h_last;
      v_last_q <= v_last;
    end
  end

  // Settle counter: settle lasts cycle_time cycles, never less than one.
  always_ff @(posedge clk_stream or posedge rst_stream) begin
    if (rst_stream) begin
      settle_cnt <= '0;
    end else if (settle_load) begin
      settle_cnt <= (cycle_q == '0) ? '0 : cycle_q - 1'b1;
    end else if ((state == S_SETTLE) && (settle_cnt != '0)) begin
      settle_cnt <= settle_cnt - 1'b1;
    end
  end

  // Pixel timeout counter, zero on the first PIXEL cycle.
  always_ff @(posedge clk_stream or posedge rst_stream) begin
    if (rst_stream) begin
      to_cnt <= '0;
    end else if (state == S_PIXEL) begin
      to_cnt <= to_cnt + 1'b1;
    end else begin
      to_cnt <= '0;
    end
  end

  // Sticky timeout flag; a coincident pixel_done counts as completion.
  always_ff @(posedge clk_stream or posedge rst_stream) begin
    if (rst_stream) begin
      pixel_timeout <= 1'b0;
    end else if (timeout_hit && !pixel_done) begin
      pixel_timeout <= 1'b1;
    end else if (timeout_clr) begin
      pixel_timeout <= 1'b0;
    end
  end

  // Galvo position and frame counter; both hold across a halt.
  always_ff @(posedge clk_stream or posedge rst_stream) begin
    if (rst_stream) begin
      galvoh      <= '0;
      galvov      <= '0;
      frame_count <= '0;
    end else if (start_scan) begin
      galvoh      <= '0;
      galvov      <= '0;
      frame_count <= '0;
    end else if (step_h) begin
      galvoh <= h_step;
    end else if (step_row) begin
      galvoh <= h_row_start;
      galvov <= galvov + 1'b1;
    end else if (wrap_frame) begin
      galvoh      <= '0;
      galvov      <= '0;
      frame_count <= frame_count + 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mc_scan_sequencer.sv
//==============================================================================
// Module   : tb_mc_scan_sequencer
// Purpose  : Self-checking bench for mc_scan_sequencer with a position
//            scoreboard and automatic galvo SPI / pixel_done responders.
//            Honours MC_SERPENTINE_EN for the expected scan order.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_mc_scan_sequencer;

  localparam int              H_W     = 11;
  localparam int              V_W     = 11;
  localparam int              CYC_W   = 10;
  localparam int              TO_W    = 16;
  localparam int              FRAME_W = 16;
  localparam logic [TO_W-1:0] TO_VAL  = 16'd16;
`ifdef MC_SERPENTINE_EN
  localparam bit SERP = 1'b1;
`else
  localparam bit SERP = 1'b0;
`endif

  logic               clk_stream = 1'b0;
  logic               rst_stream = 1'b1;
  logic               run = 1'b0;
  logic               halt = 1'b0;
  logic [1:0]         mode = 2'd0;
  logic [CYC_W-1:0]   cycle_time = '0;
  logic [H_W-1:0]     h_last = '0;
  logic [V_W-1:0]     v_last = '0;
  logic               timeout_clr = 1'b0;
  logic               galvo_spi_done = 1'b0;
  logic               pixel_done = 1'b0;
  logic               galvo_req;
  logic [H_W-1:0]     galvoh;
  logic [V_W-1:0]     galvov;
  logic               go;
  logic               busy;
  logic               frame_done;
  logic [FRAME_W-1:0] frame_count;
  logic               pixel_timeout;

  typedef struct packed {
    logic [H_W-1:0] h;
    logic [V_W-1:0] v;
  } pos_t;

  pos_t exp_req_q[$];
  pos_t exp_go_q[$];
  pos_t mon_p;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int last_spi = -1;
  int last_pix = -1;
  int first_go = -1;
  int n_req = 0;
  int n_go = 0;
  int n_fd = 0;
  int go_lat_spi = 0;
  int go_lat_pix = 0;
  bit spi_en = 1'b1;
  int pix_skip = 0;
  int pix_budget = 0;
  int pix_delay = 2;

  mc_scan_sequencer #(
    .H_W     (H_W),
    .V_W     (V_W),
    .CYC_W   (CYC_W),
    .TO_W    (TO_W),
    .TIMEOUT (TO_VAL),
    .FRAME_W (FRAME_W)
  ) dut (
    .clk_stream     (clk_stream),
    .rst_stream     (rst_stream),
    .run            (run),
    .halt           (halt),
    .mode           (mode),
    .cycle_time     (cycle_time),
    .h_last         (h_last),
    .v_last         (v_last),
    .timeout_clr    (timeout_clr),
    .galvo_spi_done (galvo_spi_done),
    .pixel_done     (pixel_done),
    .galvo_req      (galvo_req),
    .galvoh         (galvoh),
    .galvov         (galvov),
    .go             (go),
    .busy           (busy),
    .frame_done     (frame_done),
    .frame_count    (frame_count),
    .pixel_timeout  (pixel_timeout)
  );

  initial forever #5 clk_stream = ~clk_stream;

  // Cycle counter; input pulses are timestamped at the edge that samples them.
  initial forever begin
    @(posedge clk_stream);
    if (galvo_spi_done) last_spi = cyc;
    if (pixel_done) last_pix = cyc;
    cyc = cyc + 1;
  end

  // Galvo SPI model: completion two cycles after each request.
  initial forever begin
    @(negedge clk_stream);
    if (!rst_stream && galvo_req && spi_en) begin
      repeat (2) @(negedge clk_stream);
      galvo_spi_done = 1'b1;
      @(negedge clk_stream);
      galvo_spi_done = 1'b0;
    end
  end

  // input_top model: pixel_done pix_delay cycles after go, with skip/budget.
  initial forever begin
    @(negedge clk_stream);
    if (!rst_stream && go) begin
      if (pix_skip > 0) begin
        pix_skip = pix_skip - 1;
      end else if (pix_budget > 0) begin
        pix_budget = pix_budget - 1;
        repeat (pix_delay) @(negedge clk_stream);
        pixel_done = 1'b1;
        @(negedge clk_stream);
        pixel_done = 1'b0;
      end
    end
  end

  // Scoreboard: positions of galvo_req and go, plus go latency.
  initial forever begin
    @(negedge clk_stream);
    if (!rst_stream) begin
      if (galvo_req) begin
        n_req = n_req + 1;
        checks = checks + 1;
        if (exp_req_q.size() == 0) begin
          failures = failures + 1;
          $display("FAIL galvo_req_extra: req at (%0d,%0d) cycle %0d, required none", galvoh, galvov, cyc);
        end else begin
          mon_p = exp_req_q.pop_front();
          if (galvoh !== mon_p.h || galvov !== mon_p.v) begin
            failures = failures + 1;
            $display("FAIL galvo_req_pos: got (%0d,%0d) required (%0d,%0d)", galvoh, galvov, mon_p.h, mon_p.v);
          end
        end
      end
      if (go) begin
        n_go = n_go + 1;
        if (n_go == 1) first_go = cyc;
        checks = checks + 1;
        if (exp_go_q.size() == 0) begin
          failures = failures + 1;
          $display("FAIL go_extra: go at (%0d,%0d) cycle %0d, required none", galvoh, galvov, cyc);
        end else begin
          mon_p = exp_go_q.pop_front();
          if (galvoh !== mon_p.h || galvov !== mon_p.v) begin
            failures = failures + 1;
            $display("FAIL go_pos: got (%0d,%0d) required (%0d,%0d)", galvoh, galvov, mon_p.h, mon_p.v);
          end
        end
        if (last_pix > last_spi) begin
          if (go_lat_pix != 0) begin
            checks = checks + 1;
            if (cyc - last_pix != go_lat_pix) begin
              failures = failures + 1;
              $display("FAIL go_after_pixel_done: got %0d cycles required %0d", cyc - last_pix, go_lat_pix);
            end
          end
        end else if (go_lat_spi != 0) begin
          checks = checks + 1;
          if (cyc - last_spi != go_lat_spi) begin
            failures = failures + 1;
            $display("FAIL go_after_spi_done: got %0d cycles required %0d", cyc - last_spi, go_lat_spi);
          end
        end
      end
      if (frame_done) n_fd = n_fd + 1;
    end
  end

  task automatic clear_state();
    exp_req_q.delete();
    exp_go_q.delete();
    n_req = 0;
    n_go = 0;
    n_fd = 0;
    last_spi = -1;
    last_pix = -1;
    first_go = -1;
    go_lat_spi = 0;
    go_lat_pix = 0;
    pix_skip = 0;
    pix_budget = 1000;
    pix_delay = 2;
  endtask

  // Model of the raster order, pushed before the scan is started.
  task automatic push_frame(input int hl, input int vl);
    pos_t p;
    for (int v = 0; v <= vl; v++) begin
      for (int k = 0; k <= hl; k++) begin
        p.h = (SERP && (v % 2 == 1)) ? H_W'(hl - k) : H_W'(k);
        p.v = V_W'(v);
        exp_req_q.push_back(p);
        exp_go_q.push_back(p);
      end
    end
  endtask

  task automatic start_scan(input logic [1:0] m, input int ct, input int hl, input int vl);
    @(negedge clk_stream);
    mode       = m;
    cycle_time = CYC_W'(ct);
    h_last     = H_W'(hl);
    v_last     = V_W'(vl);
    run        = 1'b1;
    @(negedge clk_stream);
    run = 1'b0;
  endtask

  task automatic wait_idle(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk_stream);
      if (!busy) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_go(input int n, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk_stream);
      if (n_go >= n) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_fd(input int n, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk_stream);
      if (n_fd >= n) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    logic [H_W+V_W+FRAME_W+4:0] outs;
    repeat (3) @(negedge clk_stream);
    outs = {busy, go, galvo_req, frame_done, pixel_timeout, frame_count, galvoh, galvov};
    checks = checks + 1;
    if (outs !== '0) begin
      failures = failures + 1;
      $display("FAIL reset_outputs: got %h required 0", outs);
    end
    rst_stream = 1'b0;
    repeat (2) @(negedge clk_stream);
    checks = checks + 1;
    if (busy !== 1'b0) begin
      failures = failures + 1;
      $display("FAIL reset_idle_busy: got %b required 0", busy);
    end
  endtask

  task automatic test_raster();
    bit ok;
    clear_state();
    go_lat_spi = 4;
    push_frame(2, 1);
    start_scan(2'd0, 3, 2, 1);
    wait_idle(600, ok);
    checks = checks + 1;
    if (!ok) begin
      failures = failures + 1;
      $display("FAIL raster_busy_fall: busy still %b required 0", busy);
    end
    checks = checks + 1;
    if (n_req != 6 || n_go != 6) begin
      failures = failures + 1;
      $display("FAIL raster_counts: got req=%0d go=%0d required 6/6", n_req, n_go);
    end
    checks = checks + 1;
    if (n_fd != 1 || frame_count !== 16'd1) begin
      failures = failures + 1;
      $display("FAIL raster_frame: got frame_done=%0d frame_count=%0d required 1/1", n_fd, frame_count);
    end
    checks = checks + 1;
    if (exp_req_q.size() + exp_go_q.size() != 0) begin
      failures = failures + 1;
      $display("FAIL raster_missing: %0d expected events left, required 0", exp_req_q.size() + exp_go_q.size());
    end
    checks = checks + 1;
    if (galvoh !== '0 || galvov !== '0) begin
      failures = failures + 1;
      $display("FAIL raster_home: got (%0d,%0d) required (0,0)", galvoh, galvov);
    end
  endtask

  task automatic test_continuous();
    bit ok;
    pos_t p;
    clear_state();
    go_lat_spi = 2;
    pix_budget = 5;
    p = '0;
    for (int i = 0; i < 6; i++) begin
      exp_req_q.push_back(p);
      exp_go_q.push_back(p);
    end
    start_scan(2'd1, 1, 0, 0);
    wait_fd(5, 400, ok);
    checks = checks + 1;
    if (!ok) begin
      failures = failures + 1;
      $display("FAIL cont_frames: got %0d frame_done required 5", n_fd);
    end
    wait_go(6, 100, ok);
    checks = checks + 1;
    if (!ok || busy !== 1'b1 || frame_count !== 16'd5) begin
      failures = failures + 1;
      $display("FAIL cont_running: got go=%0d busy=%b frame_count=%0d required 6/1/5", n_go, busy, frame_count);
    end
    halt = 1'b1;
    @(negedge clk_stream);
    checks = checks + 1;
    if (busy !== 1'b0) begin
      failures = failures + 1;
      $display("FAIL cont_halt_idle: got busy=%b required 0", busy);
    end
    repeat (30) @(negedge clk_stream);
    halt = 1'b0;
    checks = checks + 1;
    if (n_go != 6 || n_fd != 5 || frame_count !== 16'd5 || pixel_timeout !== 1'b0) begin
      failures = failures + 1;
      $display("FAIL cont_after_halt: got go=%0d fd=%0d fc=%0d to=%b required 6/5/5/0", n_go, n_fd, frame_count, pixel_timeout);
    end
  endtask

  task automatic test_point();
    bit ok;
    pos_t p;
    clear_state();
    go_lat_pix = 3;
    pix_budget = 4;
    p = '0;
    exp_req_q.push_back(p);
    for (int i = 0; i < 5; i++) exp_go_q.push_back(p);
    start_scan(2'd2, 0, 2, 1);
    wait_go(5, 300, ok);
    checks = checks + 1;
    if (!ok) begin
      failures = failures + 1;
      $display("FAIL point_go_count: got %0d go required 5", n_go);
    end
    halt = 1'b1;
    @(negedge clk_stream);
    checks = checks + 1;
    if (busy !== 1'b0) begin
      failures = failures + 1;
      $display("FAIL point_halt_idle: got busy=%b required 0", busy);
    end
    repeat (20) @(negedge clk_stream);
    halt = 1'b0;
    checks = checks + 1;
    if (n_req != 1 || n_go != 5 || n_fd != 0) begin
      failures = failures + 1;
      $display("FAIL point_counts: got req=%0d go=%0d fd=%0d required 1/5/0", n_req, n_go, n_fd);
    end
  endtask

  task automatic test_timeout_tie();
    bit ok;
    clear_state();
    go_lat_spi = 2;
    pix_delay = 15;
    push_frame(0, 0);
    start_scan(2'd3, 0, 0, 0);
    wait_idle(200, ok);
    checks = checks + 1;
    if (!ok || n_fd != 1 || frame_count !== 16'd1) begin
      failures = failures + 1;
      $display("FAIL tie_frame: got idle=%b fd=%0d fc=%0d required 1/1/1", ok, n_fd, frame_count);
    end
    checks = checks + 1;
    if (pixel_timeout !== 1'b0) begin
      failures = failures + 1;
      $display("FAIL tie_no_flag: got pixel_timeout=%b required 0", pixel_timeout);
    end
  endtask

  task automatic test_timeout();
    bit ok;
    clear_state();
    go_lat_spi = 2;
    pix_skip = 1;
    push_frame(1, 0);
    start_scan(2'd0, 1, 1, 0);
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk_stream);
      if (pixel_timeout) begin
        ok = 1'b1;
        break;
      end
    end
    checks = checks + 1;
    if (!ok || cyc - first_go != 16) begin
      failures = failures + 1;
      $display("FAIL timeout_latency: got set=%b after %0d cycles required 1 after 16", ok, cyc - first_go);
    end
    wait_idle(200, ok);
    checks = checks + 1;
    if (!ok || n_go != 2 || n_fd != 1) begin
      failures = failures + 1;
      $display("FAIL timeout_advance: got idle=%b go=%0d fd=%0d required 1/2/1", ok, n_go, n_fd);
    end
    checks = checks + 1;
    if (pixel_timeout !== 1'b1) begin
      failures = failures + 1;
      $display("FAIL timeout_sticky: got %b required 1", pixel_timeout);
    end
    timeout_clr = 1'b1;
    @(negedge clk_stream);
    timeout_clr = 1'b0;
    checks = checks + 1;
    if (pixel_timeout !== 1'b0) begin
      failures = failures + 1;
      $display("FAIL timeout_clear: got %b required 0", pixel_timeout);
    end
  endtask

  task automatic test_run_halt_same();
    clear_state();
    @(negedge clk_stream);
    mode = 2'd0;
    run  = 1'b1;
    halt = 1'b1;
    @(negedge clk_stream);
    checks = checks + 1;
    if (busy !== 1'b0) begin
      failures = failures + 1;
      $display("FAIL same_edge_busy: got %b required 0", busy);
    end
    repeat (5) @(negedge clk_stream);
    run  = 1'b0;
    halt = 1'b0;
    repeat (2) @(negedge clk_stream);
    checks = checks + 1;
    if (n_req != 0 || busy !== 1'b0) begin
      failures = failures + 1;
      $display("FAIL same_edge_req: got req=%0d busy=%b required 0/0", n_req, busy);
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    clear_state();
    go_lat_spi = 4;
    push_frame(2, 1);
    start_scan(2'd0, 3, 2, 1);
    wait_go(2, 200, ok);
    mode       = 2'd1;
    cycle_time = '0;
    h_last     = '0;
    v_last     = '0;
    run        = 1'b1;
    @(negedge clk_stream);
    run = 1'b0;
    wait_idle(600, ok);
    checks = checks + 1;
    if (!ok || n_req != 6 || n_go != 6) begin
      failures = failures + 1;
      $display("FAIL midscan_counts: got idle=%b req=%0d go=%0d required 1/6/6", ok, n_req, n_go);
    end
    checks = checks + 1;
    if (n_fd != 1 || frame_count !== 16'd1) begin
      failures = failures + 1;
      $display("FAIL midscan_frame: got fd=%0d fc=%0d required 1/1", n_fd, frame_count);
    end
  endtask

  initial begin
    test_reset();
    test_raster();
    test_continuous();
    test_point();
    test_timeout_tie();
    test_timeout();
    test_run_halt_same();
    test_back_to_back();
    repeat (5) @(negedge clk_stream);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    failures = failures + 1;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire

// File: doc/mc_scan_sequencer.md
Name: mc_scan_sequencer

Overview:
Parametrised successor to the master controller's fixed-rate GO generator. Sequences a full raster scan: for each pixel it commands a galvo move, waits for SPI completion, waits a programmable settle time, issues GO to input_top, then waits for pixel_done. Supports single-frame, continuous and point (stare) modes, with a pixel timeout and frame counting. Sits in the clk_stream domain between the control-register CDC and the galvo SPI / input_top blocks.

Parameters:
H_W, 11, width of horizontal galvo position
V_W, 11, width of vertical galvo position
CYC_W, 10, width of settle-time count
TO_W, 16, width of pixel timeout counter
TIMEOUT, 16'hFFFF, clk_stream cycles to wait for pixel_done before forced advance
FRAME_W, 16, width of frame counter

Ports:
clk_stream  in  1  stream clock (250 MHz); sole clock
rst_stream  in  1  asynchronous, active-high reset
run  in  1  level, already synchronised; rising edge starts a scan
halt  in  1  level, already synchronised; rising edge aborts
mode  in  2  0 single frame, 1 continuous, 2 point, 3 reserved (treated as 0)
cycle_time  in  CYC_W  settle cycles after galvo_spi_done
h_last  in  H_W  last horizontal index (columns = h_last+1)
v_last  in  V_W  last vertical index
timeout_clr  in  1  clears pixel_timeout sticky
galvo_spi_done  in  1  single-cycle pulse, galvo move complete (synchronised)
pixel_done  in  1  single-cycle pulse from input_top (synchronised)
galvo_req  out  1  single-cycle request to galvo SPI
galvoh  out  H_W  commanded horizontal position
galvov  out  V_W  commanded vertical position
go  out  1  single-cycle pixel start to input_top
busy  out  1  high when state != IDLE
frame_done  out  1  single-cycle pulse at end of each frame
frame_count  out  FRAME_W  completed frames since last run edge
pixel_timeout  out  1  sticky timeout flag

Behaviour:
- Reset: all outputs 0; state IDLE; counters 0.
- run/halt edge-detected internally (registered previous value, reset 0).
- States: IDLE, GALVO, SETTLE, PIXEL, ADVANCE.
- IDLE: on run edge latch mode, cycle_time, h_last, v_last (config ignored mid-scan); galvoh=galvov=0; frame_count=0; -> GALVO.
- GALVO: galvo_req=1 on first cycle of entry only; galvoh/galvov stable throughout; wait galvo_spi_done -> SETTLE. galvo_spi_done in the same cycle as galvo_req is accepted.
- SETTLE: load cycle_time, decrement each cycle; leave when count==0 -> PIXEL. cycle_time=0 gives exactly 1 SETTLE cycle.
- PIXEL: go=1 on first cycle of entry only; wait pixel_done -> ADVANCE. Timeout counter starts at entry; reaching TIMEOUT sets pixel_timeout and forces -> ADVANCE. pixel_done and timeout in the same cycle: treated as done, flag not set.
- ADVANCE (1 cycle):
  - mode 2: stay at current position -> SETTLE (no galvo move, no frame_done).
  - galvoh<h_last: galvoh+1 -> GALVO.
  - galvoh==h_last, galvov<v_last: galvoh=0, galvov+1 -> GALVO.
  - both last: frame_done=1, frame_count+1 (wraps); galvoh=galvov=0; mode 1 -> GALVO, else -> IDLE.
- halt edge: highest priority; any state -> IDLE next cycle; go/galvo_req/frame_done forced 0 that cycle; galvoh/galvov hold; frame_count holds. Simultaneous run and halt edges: halt wins, stays IDLE.
- run edge while busy: ignored.
- pixel_timeout: set has priority over timeout_clr; cleared only by timeout_clr or reset.
- h_last=v_last=0: one-pixel frame, frame_done after every pixel.

Optional Feature:
MC_SERPENTINE_EN: when defined, odd rows scan right-to-left (galvoh counts down from h_last to 0) to remove flyback; row 0 starts at galvoh=0; row change keeps galvoh at the row end; frame end returns to (0,0). Undefined: every row scans 0..h_last, galvoh returns to 0 at row change.

Test Plan:
- h_last=2, v_last=1, mode 0, cycle_time=3, done pulses 2 cycles after each request -> 6 galvo_req, 6 go, order (0,0)(1,0)(2,0)(0,1)(1,1)(2,1), one frame_done, frame_count=1, busy falls; go exactly 4 cycles after each galvo_spi_done.
- mode 1, h_last=v_last=0, 5 pixels serviced -> frame_done 5 times, frame_count=5, busy stays 1; halt edge -> IDLE next cycle, no further go.
- mode 2, cycle_time=0 -> one galvo_req then go repeats every pixel_done+3 cycles at (0,0), never frame_done.
- PIXEL with pixel_done withheld, TIMEOUT=16 -> pixel_timeout set 16 cycles after go, scan advances; timeout_clr -> flag 0.
- run and halt rising in same cycle -> busy stays 0, no galvo_req; run edge mid-scan -> scan unaffected.
- MC_SERPENTINE_EN, h_last=2, v_last=1 -> order (0,0)(1,0)(2,0)(2,1)(1,1)(0,1).
